bcd_seg_scan: RTL and testbench

Multiplexed two-digit 7-segment display driver that sits directly downstream of the binary-to-BCD converter in the number-system datapath. It accepts a packed two-digit BCD byte through a valid/ready handshake and holds it in a one-deep pending buffer. At each frame boundary it commits the pending value and time-multiplexes the two digits onto a shared segment bus, with anti-ghosting guard intervals between digits. Invalid nibbles (>9) are flagged and shown as "E".

---
 rtl/bcd_seg_pkg.sv | 38 +++
 rtl/bcd_seg_scan_if.sv | 12 +
 rtl/bcd_to_seg7.sv | 31 +++
 rtl/bcd_seg_scan.sv | 131 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment patterns are active-high, bit0=a .. bit6=g.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        S_D0 = 2'd0,
        S_G0 = 2'd1,
        S_D1 = 2'd2,
        S_G1 = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam int DIG_UNITS = 0;
    localparam int DIG_TENS  = 1;

    typedef struct packed {
        scan_state_t state;
        logic        pending;
        logic        digit_err;
    } scan_dbg_t;

    function automatic logic bcd_byte_bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Upstream BCD handshake bundle between the binary-to-BCD converter and the scanner.
interface bcd_seg_scan_if;
    // A byte moves on a rising clock edge where bcd_valid && bcd_ready. The master
    // holds bcd_in stable while bcd_valid is high and not yet accepted; bcd_ready
    // never depends on bcd_valid.
    logic [7:0] bcd_in;
    logic       bcd_valid;
    logic       bcd_ready;

    modport master (output bcd_in, output bcd_valid, input  bcd_ready);
    modport slave  (input  bcd_in, input  bcd_valid, output bcd_ready);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment pattern; values A-F show "E".
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg,
    output logic       err
);

    always_comb begin
        seg = SEG_E;
        err = 1'b0;
        unique case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: begin
                seg = SEG_E;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver with a one-deep pending buffer committed at
// frame boundaries. Optional leading-zero blanking: define BCD_SEG_LZB_EN.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int DIV            = 50000,
    parameter int GUARD          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_seg_scan_if.slave        bus,
    output logic [6:0]           seg,
    output logic [1:0]           dig_en,
    output logic                 bcd_err,
    output scan_dbg_t            dbg
);

    localparam int PH_MAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CNT_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [6:0] SEG_XOR = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_XOR = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

`ifdef BCD_SEG_LZB_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    scan_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             phase_last;
    logic             pending;
    logic [7:0]       pend_reg;
    logic [7:0]       disp_reg;
    logic             transfer;
    logic             commit;
    logic [3:0]       digit_nib;
    logic [6:0]       digit_seg;
    logic             digit_err;
    logic             lit_units;
    logic             lit_tens;
    logic [6:0]       seg_ah;
    logic [1:0]       dig_ah;

    assign bus.bcd_ready = !pending;
    assign transfer      = bus.bcd_valid && !pending;
    assign commit        = (state == S_G1) && phase_last && pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_D0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        phase_last = ((state == S_D0) || (state == S_D1)) ? (cnt == DIV_LAST)
                                                          : (cnt == GUARD_LAST);
        if (phase_last) begin
            cnt_nx = '0;
            unique case (state)
                S_D0:    state_nx = S_G0;
                S_G0:    state_nx = S_D1;
                S_D1:    state_nx = S_G1;
                default: state_nx = S_D0;
            endcase
        end
    end

    // transfer needs pending=0 and commit needs pending=1, so they are exclusive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            pend_reg <= 8'h00;
            disp_reg <= 8'h00;
            bcd_err  <= 1'b0;
        end else if (transfer) begin
            pend_reg <= bus.bcd_in;
            pending  <= 1'b1;
        end else if (commit) begin
            disp_reg <= pend_reg;
            pending  <= 1'b0;
            bcd_err  <= bcd_byte_bad(pend_reg);
        end
    end

    assign digit_nib = (state == S_D1) ? disp_reg[7:4] : disp_reg[3:0];

    bcd_to_seg7 u_dec (
        .nibble (digit_nib),
        .seg    (digit_seg),
        .err    (digit_err)
    );

    assign lit_units = (state == S_D0);
    assign lit_tens  = (state == S_D1) && !(LZB_EN && (disp_reg[7:4] == 4'd0));

    always_comb begin
        dig_ah            = 2'b00;
        dig_ah[DIG_UNITS] = lit_units;
        dig_ah[DIG_TENS]  = lit_tens;
        seg_ah            = (lit_units || lit_tens) ? digit_seg : SEG_OFF;
    end

    // Output registers: one cycle behind the scan state, polarity applied here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg    <= SEG_OFF ^ SEG_XOR;
            dig_en <= DIG_XOR;
        end else begin
            seg    <= seg_ah ^ SEG_XOR;
            dig_en <= dig_ah ^ DIG_XOR;
        end
    end

    always_comb begin
        dbg.state     = state;
        dbg.pending   = pending;
        dbg.digit_err = digit_err;
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: directed + random BCD bytes, frame-position reference model.
// Build with BCD_SEG_LZB_EN defined to exercise leading-zero blanking.
module tb_bcd_seg_scan;
    import bcd_seg_pkg::*;

    localparam int DIV   = 4;
    localparam int GUARD = 2;
    localparam int FRAME = 2 * (DIV + GUARD);

`ifdef BCD_SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       bcd_err;
    scan_dbg_t  dbg;

    bcd_seg_scan_if bus ();

    bcd_seg_scan #(
        .DIV            (DIV),
        .GUARD          (GUARD),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .seg     (seg),
        .dig_en  (dig_en),
        .bcd_err (bcd_err),
        .dbg     (dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic       rst_seen = 1'b0;
    logic       acc_flag = 1'b0;
    int         m_spos = 0;
    logic [7:0] m_disp = 8'h00;
    logic       m_err = 1'b0;
    logic       m_pend = 1'b0;
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    int         total = 0;
    int         bad = 0;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    function automatic logic nib_invalid(input logic [7:0] d);
        return (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    // Outputs expected for a frame position (0..FRAME-1) and a displayed byte.
    function automatic void exp_out(input int pos, input logic [7:0] d,
                                    output logic [6:0] s, output logic [1:0] g);
        logic [6:0] ah;
        logic [1:0] dg;
        ah = 7'h00;
        dg = 2'b00;
        if (pos < DIV) begin
            ah = pat(d[3:0]);
            dg = 2'b01;
        end else if (pos >= DIV + GUARD && pos < 2 * DIV + GUARD &&
                     !(LZB && d[7:4] == 4'd0)) begin
            ah = pat(d[7:4]);
            dg = 2'b10;
        end
        s = ~ah;
        g = ~dg;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h expected=%h dut_state=%0d", name, $time, act, exp,
                     dbg.state);
        end
    endtask

    // ---------------- handshake capture: expected values pushed on acceptance ----------------
    always @(posedge clk) begin
        rst_seen <= rst_n;
        acc_flag <= rst_n && bus.bcd_valid && bus.bcd_ready;
        if (!rst_n) exp_q.delete();
        else if (bus.bcd_valid && bus.bcd_ready) exp_q.push_back(bus.bcd_in);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_seen) begin
            e_seg  = 7'h7F;
            e_dig  = 2'b11;
            m_spos = 0;
            m_disp = 8'h00;
            m_err  = 1'b0;
            m_pend = 1'b0;
        end else begin
            exp_out(m_spos, m_disp, e_seg, e_dig);
            check("queue_depth", {7'b0, (exp_q.size() > 1)}, 8'h00);
            if (m_spos == FRAME - 1 && m_pend) begin
                if (exp_q.size() != 0) m_disp = exp_q.pop_front();
                m_err  = nib_invalid(m_disp);
                m_pend = 1'b0;
            end else if (!m_pend && exp_q.size() != 0) begin
                m_pend = 1'b1;
            end
            m_spos = (m_spos + 1) % FRAME;
        end
        check("seg", {1'b0, seg}, {1'b0, e_seg});
        check("dig_en", {6'b0, dig_en}, {6'b0, e_dig});
        check("bcd_err", {7'b0, bcd_err}, {7'b0, m_err});
        check("bcd_ready", {7'b0, bus.bcd_ready}, {7'b0, !m_pend});
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        bus.bcd_valid = 1'b1;
        bus.bcd_in    = v;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (acc_flag) ok = 1'b1;
        end
        bus.bcd_valid = 1'b0;
        bus.bcd_in    = 8'($urandom);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout t=%0t actual=not_accepted expected=accepted data=%h",
                     $time, v);
        end
    endtask

    task automatic reset_pulse(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit         hit;
        logic [7:0] v;
        bus.bcd_valid = 1'b0;
        bus.bcd_in    = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(FRAME + 3);

        send(8'h42);
        idle(2 * FRAME);

        send(8'h12);
        send(8'h34);
        idle(2 * FRAME + 2);

        send(8'h5A);
        idle(2 * FRAME);
        send(8'h99);
        idle(2 * FRAME);
        send(8'h07);
        idle(2 * FRAME + 5);

        // Reset while the tens digit is lit and a value is waiting.
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            @(negedge clk);
            if (m_spos == DIV + GUARD) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL find_tens_phase t=%0t actual=not_found expected=found", $time);
        end
        send(8'h88);
        reset_pulse(1);
        idle(2 * FRAME + 4);

        for (int n = 0; n < 50; n++) begin
            idle($urandom_range(0, 14));
            if ($urandom_range(0, 11) == 0) reset_pulse($urandom_range(1, 2));
            if ($urandom_range(0, 3) == 0) v = 8'($urandom);
            else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            send(v);
        end
        idle(2 * FRAME + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
